// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: demand-actuated round-robin four-way signal controller
module traffic_phase_arbiter #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW_T  = 1,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  output logic [7:0] lights,
  output logic [3:0] grant,
  output logic [3:0] pending,
  output logic [1:0] phase
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(MAX_GREEN + 1);
  typedef enum logic [1:0] {ALLRED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [SW-1:0] sec;
  logic [1:0] last, last_n, pick;
  logic [3:0] grant_n, other, order;
  logic [7:0] lights_n;
  logic tick;
  assign tick = ena && pre == PW'(TICK_DIV - 1);
  assign other = pending & ~grant;
  assign order = {pending[0], pending[1], pending[2], pending[3]};
  // round-robin scan: first pending approach after the last one served
  always_comb begin
    pick = last;
    for (int k = 4; k >= 1; k--) if (order[2'(int'(last) + k)]) pick = 2'(int'(last) + k);
  end
  // next state, grant and last-served
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n = last;
    case (state)
      ALLRED: if (tick && int'(sec) + 1 >= ALLRED_T && |pending) begin
        state_n = GREEN;
        grant_n = 4'b1000 >> pick;
        last_n = pick;
      end
      GREEN: if (tick && |other && (int'(sec) + 1 >= MAX_GREEN ||
                 (int'(sec) + 1 >= MIN_GREEN && !(|(req & grant))))) state_n = YELLOW;
      YELLOW: if (tick && int'(sec) + 1 >= YELLOW_T) begin
        state_n = ALLRED;
        grant_n = '0;
      end
      default: begin
        state_n = ALLRED;
        grant_n = '0;
      end
    endcase
  end
  // light codes follow the next state so they register on the transition edge
  always_comb begin
    lights_n = '0;
    for (int i = 0; i < 4; i++)
      lights_n[2*i +: 2] = !grant_n[i] ? 2'b00 : state_n == GREEN ? 2'b10 : state_n == YELLOW ? 2'b01 : 2'b00;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ALLRED;
      grant <= '0;
      last <= 2'd3;
      lights <= '0;
      phase <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last <= last_n;
      lights <= lights_n;
      phase <= state_n;
    end
  // prescaler and saturating tick counter, restarted on every state entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      sec <= '0;
    end else if (state_n != state) begin
      pre <= '0;
      sec <= '0;
    end else if (ena) begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick && int'(sec) < MAX_GREEN) sec <= sec + 1'b1;
    end
  // request latch: set by demand unless already green, cleared when served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= (pending | (req & ~(state == GREEN ? grant : 4'b0)))
                    & ~((state_n == GREEN && state != GREEN) ? grant_n : 4'b0);
endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb_traffic_phase_arbiter: directed and random checks against a behavioural model
module tb_traffic_phase_arbiter;
  localparam int TD = 4, MING = 2, MAXG = 4, YT = 1, ART = 1;
  logic clk = 0, rst_n = 0, ena = 0;
  logic [3:0] req = 0;
  logic [7:0] lights;
  logic [3:0] grant, pending;
  logic [1:0] phase;
  int errors = 0, checks = 0;

  traffic_phase_arbiter #(.TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_T(YT), .ALLRED_T(ART)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .lights(lights), .grant(grant), .pending(pending), .phase(phase));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int g);
    return g < 0 ? 4'b0 : 4'b1000 >> g;
  endfunction

  function automatic logic [7:0] exp_lights(input int ph, input int g);
    logic [7:0] l = 0;
    if (g >= 0 && ph != 0) l[7-2*g -: 2] = ph == 1 ? 2'b10 : 2'b01;
    return l;
  endfunction

  // model: phase 0=allred 1=green 2=yellow, g = approach index (0=N..3=W), cyc = enabled cycles in phase
  int m_ph, m_g, m_last, m_cyc, k;
  logic [3:0] m_pend, np;
  bit tk, go;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ph = 0; m_g = -1; m_last = 3; m_cyc = 0; m_pend = 0;
    end else begin
      np = m_pend | (req & ~(m_ph == 1 ? onehot(m_g) : 4'b0));
      tk = 0; k = 0; go = 0;
      if (ena) begin
        m_cyc++;
        tk = (m_cyc % TD) == 0;
        k = m_cyc / TD;
      end
      if (tk) begin
        if (m_ph == 0 && k >= ART && m_pend != 0) begin
          for (int s = 1; s <= 4; s++)
            if (!go && m_pend[3 - ((m_last + s) % 4)]) begin
              m_g = (m_last + s) % 4;
              go = 1;
            end
          m_last = m_g; np = np & ~onehot(m_g); m_ph = 1; m_cyc = 0;
        end else if (m_ph == 1 && (m_pend & ~onehot(m_g)) != 0 &&
                     (k >= MAXG || (k >= MING && !req[3 - m_g]))) begin
          m_ph = 2; m_cyc = 0;
        end else if (m_ph == 2 && k >= YT) begin
          m_ph = 0; m_g = -1; m_cyc = 0;
        end
      end
      m_pend = np;
    end

  always @(negedge clk)
    if (rst_n) begin
      check("lights", lights, exp_lights(m_ph, m_g));
      check("grant", {4'b0, grant}, {4'b0, m_ph == 0 ? 4'b0 : onehot(m_g)});
      check("pending", {4'b0, pending}, {4'b0, m_pend});
      check("phase", {6'b0, phase}, {6'b0, 2'(m_ph)});
    end

  task automatic run_len(output int n);
    logic [7:0] v;
    v = lights;
    n = 0;
    while (lights == v && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n, tot;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_lights", lights, 8'h00);
    check("reset_grant", {4'b0, grant}, 8'h00);
    check("reset_phase", {6'b0, phase}, 8'h00);
    ena = 1;
    rst_n = 1;
    repeat (100) @(negedge clk);
    check("idle_lights", lights, 8'h00);
    check("idle_phase", {6'b0, phase}, 8'h00);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk); req = 4'b1000;
    @(negedge clk); req = 4'b0000;
    @(negedge clk);
    check("pre_green", lights, 8'h00);
    @(negedge clk);
    check("first_green", lights, 8'h80);
    check("first_grant", {4'b0, grant}, 8'h08);
    req = 4'b1000;
    repeat (30) @(negedge clk);
    check("green_hold", lights, 8'h80);
    req = 4'b1010;
    @(negedge clk); req = 4'b1000;
    run_len(n);
    check("n_yellow", lights, 8'h40);
    run_len(n);
    check("yellow_len", 8'(n), 8'd4);
    check("allred", lights, 8'h00);
    run_len(n);
    check("allred_len", 8'(n), 8'd4);
    check("s_green", lights, 8'h08);
    check("s_grant", {4'b0, grant}, 8'h02);
    run_len(n);
    check("s_gapout_len", 8'(n), 8'd8);
    run_len(n);
    run_len(n);
    check("n_again", lights, 8'h80);
    req = 4'b0100;
    @(negedge clk); req = 4'b0000;
    run_len(n);
    check("n_gapout_len", 8'(n), 8'd7);
    check("n_gap_yellow", lights, 8'h40);
    run_len(n);
    run_len(n);
    check("e_green", lights, 8'h20);
    req = 4'b1111;
    n = 0;
    while (!(grant == 4'b1000 && phase == 2'b01) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rr_sync", {4'b0, grant}, 8'h08);
    for (int i = 0; i < 5; i++) begin
      check("rr_grant", {4'b0, grant}, {4'b0, 4'b1000 >> (i % 4)});
      run_len(n);
      check("rr_green_len", 8'(n), 8'd16);
      run_len(n);
      run_len(n);
    end
    repeat (5) @(negedge clk);
    ena = 0;
    repeat (20) @(negedge clk);
    ena = 1;
    run_len(n);
    tot = 25 + n;
    check("freeze_len", 8'(tot), 8'd36);
    n = 0;
    while (phase != 2'b10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("yellow_found", {6'b0, phase}, 8'h02);
    #2 rst_n = 0;
    #1;
    check("async_lights", lights, 8'h00);
    check("async_grant", {4'b0, grant}, 8'h00);
    check("async_pending", {4'b0, pending}, 8'h00);
    check("async_phase", {6'b0, phase}, 8'h00);
    @(negedge clk);
    rst_n = 1;
    req = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) req[b] = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 199) == 0) req = 4'b0000;
      ena = $urandom_range(0, 9) != 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
